minterm_sweep_ctrl: RTL and testbench



---
 rtl/ddhw_sweep_pkg.sv | 17 +
 rtl/settle_timer.sv | 30 +++
 rtl/minterm_sweep_ctrl.sv | 120 ++++++++++++
 tb/tb_minterm_sweep_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/ddhw_sweep_pkg.sv
// Shared types and constants for the minterm sweep controller and its settle timer.
package ddhw_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_N_IN   = 4;
  localparam int DEF_SETTLE = 2;

  // Golden table for F = A(B + (CD)') + BC', bit i = F(vec == i)
  localparam logic [15:0] F3_32B_TABLE = 16'hF730;

endpackage

// File: rtl/settle_timer.sv
// 8-bit loadable up/down counter; tc flags the terminal value for the current direction
// (count == term when counting up, count == 0 when counting down).
module settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  input  logic       up,
  input  logic [7:0] load_val,
  input  logic [7:0] term,
  output logic       tc
);

  logic [7:0] count;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= up ? count + 8'd1 : count - 8'd1;
    end
  end

  assign tc = up ? (count == term) : (count == 8'd0);

endmodule

// File: rtl/minterm_sweep_ctrl.sv
// Drives every minterm of an N_IN-input function in ascending order and captures its truth table.
// Optional golden-table comparison on the pass output is built only with SWEEP_EXPECT_CHECK_EN.
module minterm_sweep_ctrl
  import ddhw_sweep_pkg::*;
#(
  parameter int                  N_IN          = DEF_N_IN,
  parameter int                  SETTLE_CYCLES = DEF_SETTLE,
  parameter logic [2**N_IN-1:0]  EXPECTED      = F3_32B_TABLE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [N_IN-1:0]      vec,
  input  logic                 f_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   truth_table,
  output logic                 pass
);

  localparam logic [7:0] SETTLE_TERM = 8'(SETTLE_CYCLES);

  state_t              state, state_next;
  logic                timer_load, timer_en, timer_tc;
  logic                last_vec;
  logic [2**N_IN-1:0]  table_merged;

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .en       (timer_en),
    .up       (1'b1),
    .load_val (8'd0),
    .term     (SETTLE_TERM),
    .tc       (timer_tc)
  );

  assign last_vec = (vec == {N_IN{1'b1}});

  // NOTE: every always_comb output gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next        = state;
    timer_load        = 1'b0;
    timer_en          = 1'b0;
    table_merged      = truth_table;
    table_merged[vec] = f_in;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SETTLE;
          timer_load = 1'b1;
        end
      end
      SETTLE: begin
        if (timer_tc) state_next = SAMPLE;
        else          timer_en   = 1'b1;
      end
      SAMPLE: begin
        if (last_vec) begin
          state_next = DONE;
        end else begin
          state_next = SETTLE;
          timer_load = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // busy/done are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      truth_table <= '0;
    end else begin
      busy <= (state_next == SETTLE) || (state_next == SAMPLE);
      done <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            vec         <= '0;
            truth_table <= '0;
          end
        end
        SAMPLE: begin
          truth_table <= table_merged;
          if (!last_vec) vec <= vec + 1'b1;
        end
        DONE:    vec <= '0;
        default: ;
      endcase
    end
  end

`ifdef SWEEP_EXPECT_CHECK_EN
  // Result is taken with the final sample merged, so pass is valid alongside done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass <= 1'b0;
    end else if (state == IDLE && start) begin
      pass <= 1'b0;
    end else if (state == SAMPLE && last_vec) begin
      pass <= (table_merged == EXPECTED);
    end
  end
`else
  assign pass = 1'b0;
`endif

endmodule

// File: tb/tb_minterm_sweep_ctrl.sv
// Directed bench for minterm_sweep_ctrl: default instance driven by the F3 function model,
// second instance with SETTLE_CYCLES=0 and f_in tied high.
module tb_minterm_sweep_ctrl;
  import ddhw_sweep_pkg::*;

`ifdef SWEEP_EXPECT_CHECK_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [3:0]  vec_a, vec_b;
  logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b, fa;
  logic [15:0] tbl_a, tbl_b;
  logic        glitch_en = 1'b0, glitch = 1'b0;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  minterm_sweep_ctrl dut_a (
    .clk (clk), .rst_n (rst_n), .start (start_a), .vec (vec_a), .f_in (fa),
    .busy (busy_a), .done (done_a), .truth_table (tbl_a), .pass (pass_a)
  );

  minterm_sweep_ctrl #(.SETTLE_CYCLES(0)) dut_b (
    .clk (clk), .rst_n (rst_n), .start (start_b), .vec (vec_b), .f_in (1'b1),
    .busy (busy_b), .done (done_b), .truth_table (tbl_b), .pass (pass_b)
  );

  // Reference function F = A(B + (CD)') + BC'
  function automatic logic f_ref(input logic [3:0] v);
    return (v[3] & (v[2] | ~(v[1] & v[0]))) | (v[2] & ~v[1]);
  endfunction

  assign fa = f_ref(vec_a) ^ glitch;

  // One-cycle wrong value right after every vector change
  always @(vec_a) begin
    if (glitch_en) begin
      glitch = 1'b1;
      @(posedge clk);
      #1 glitch = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Start pulse accepted at edge 0; cycle c is the interval after edge c-1, sampled at its negedge.
  task automatic sweep(input bit sel, input string tag, input int s, input bit extra,
                       input logic [15:0] exp_tbl, input bit exp_pass);
    int per, done_exp, done_cyc, n_done, busy_bad, vec_bad;
    logic dn, bz;
    logic [3:0] v;
    per = s + 2;
    done_exp = 1 + 16 * per;
    done_cyc = -1; n_done = 0; busy_bad = 0; vec_bad = 0;
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    for (int c = 1; c <= done_exp + 15; c++) begin
      @(negedge clk);
      start_b = 1'b0;
      start_a = extra && !sel && (c == 10 || c == 40);
      dn = sel ? done_b : done_a;
      bz = sel ? busy_b : busy_a;
      v  = sel ? vec_b  : vec_a;
      if (dn) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (bz !== (c < done_exp)) busy_bad++;
      if (c < done_exp && v !== 4'((c - 1) / per)) vec_bad++;
    end
    check({tag, "_done_cycle"}, done_cyc, done_exp);
    check({tag, "_done_count"}, n_done, 1);
    check({tag, "_busy_bad"}, busy_bad, 0);
    check({tag, "_vec_bad"}, vec_bad, 0);
    check({tag, "_table"}, sel ? tbl_b : tbl_a, exp_tbl);
    check({tag, "_pass"}, sel ? pass_b : pass_a, exp_pass);
  endtask

  initial begin
    int seen, first, second, n_done;
    logic [15:0] tbl_idle, tbl_restart;

    repeat (3) @(negedge clk);
    check("rst_vec", vec_a, 4'h0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_table", tbl_a, 16'h0);
    check("rst_pass", pass_a, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    sweep(1'b0, "model", 2, 1'b0, 16'hF730, FEAT);
    sweep(1'b1, "ones_s0", 0, 1'b0, 16'hFFFF, 1'b0);
    sweep(1'b0, "extra_start", 2, 1'b1, 16'hF730, FEAT);
    glitch_en = 1'b1;
    sweep(1'b0, "glitch", 2, 1'b0, 16'hF730, FEAT);
    glitch_en = 1'b0;
    @(negedge clk);

    // Reset in cycle 30 of a sweep: outputs clear asynchronously, no done afterwards
    seen = 0;
    @(negedge clk); start_a = 1'b1;
    repeat (30) begin
      @(negedge clk); start_a = 1'b0;
      if (done_a) seen++;
    end
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_vec", vec_a, 4'h0);
    check("mid_rst_busy", busy_a, 1'b0);
    check("mid_rst_table", tbl_a, 16'h0);
    check("mid_rst_pass", pass_a, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (70) begin
      @(negedge clk);
      if (done_a) seen++;
    end
    check("mid_rst_no_done", seen, 0);
    sweep(1'b0, "after_rst", 2, 1'b0, 16'hF730, FEAT);

    // start held high: restart on the first IDLE cycle after DONE, period 66 cycles
    first = -1; second = -1; n_done = 0; tbl_idle = '0; tbl_restart = '1;
    @(negedge clk); start_a = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (done_a) begin
        n_done++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      if (c == 66) tbl_idle = tbl_a;
      if (c == 67) tbl_restart = tbl_a;
    end
    start_a = 1'b0;
    check("b2b_first_done", first, 65);
    check("b2b_second_gap", second - first, 66);
    check("b2b_done_count", n_done, 3);
    check("b2b_table_held", tbl_idle, 16'hF730);
    check("b2b_table_cleared", tbl_restart, 16'h0);
    check("b2b_busy_again", busy_a, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
